// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the instruction fetch stage.
//   InstBus / InstAddrBus : instruction and address widths
//   IF_NOP_INST           : ZeroWord, presented when no instruction is valid
//   IF_RESET_PC           : default PC of the first fetch after reset
//   if_entry_t            : prefetch FIFO entry {pc, inst}
package if_fetch_pkg;

  localparam int unsigned InstBus     = 32;
  localparam int unsigned InstAddrBus = 32;

  localparam logic [InstBus-1:0]     IF_NOP_INST = '0;
  localparam logic [InstAddrBus-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_entry_t;

  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous prefetch FIFO of {pc, inst} entries.
//   clk, rst (async active-low)
//   i_push, i_data : write an entry
//   i_pop          : drop the head entry (caller guarantees not empty)
//   i_clear        : empty the FIFO; wins over push/pop
//   o_data         : head entry, o_empty, o_count : occupancy
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  if_entry_t              i_data,
  output if_entry_t              o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage. Owns the PC, issues word requests over a
// req/gnt/rvalid handshake, buffers {pc, inst} in a prefetch FIFO and presents
// the head to the IF/ID register.
//   clk, rst (async active-low)
//   stall_i, flush_i, flush_pc_i       : pipeline control / redirect
//   imem_req_o, imem_addr_o, imem_gnt_i : request channel
//   imem_rvalid_i, imem_rdata_i         : in-order response channel
//   pc_o, inst_o, valid_o               : instruction to decode
// Optional macro IF_BYPASS_EN: a response arriving while the FIFO is empty is
// presented in the same cycle instead of being registered first.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] flush_pc_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   valid_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] DepthLim = SumW'(FIFO_DEPTH);

  logic                   r_active;
  logic [InstAddrBus-1:0] r_fetch_pc;
  logic [InstAddrBus-1:0] r_resp_pc;
  logic [InstAddrBus-1:0] r_last_pc;
  logic [CntW-1:0]        r_outstanding;
  logic [CntW-1:0]        r_drop_cnt;

  logic [CntW-1:0]        w_fifo_count;
  logic [SumW-1:0]        w_credit_used;
  logic                   w_fifo_empty;
  logic                   w_req;
  logic                   w_grant;
  logic                   w_accept;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_pop;
  if_entry_t              w_head;
  if_entry_t              w_push_data;

  // Outstanding requests plus buffered words never exceed the FIFO depth, so
  // every response has a slot waiting for it.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_req         = r_active && !flush_i && (w_credit_used < DepthLim);
  assign w_grant       = w_req && imem_gnt_i;

  // A response is kept only when no stale words remain and no flush is
  // discarding it this cycle.
  assign w_accept = imem_rvalid_i && (r_drop_cnt == '0) && !flush_i;

`ifdef IF_BYPASS_EN
  assign w_bypass = w_accept && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_accept && !(w_bypass && !stall_i);
  assign w_pop       = !w_fifo_empty && !stall_i && !flush_i;
  assign w_push_data = '{pc: r_resp_pc, inst: imem_rdata_i};

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;

  always_comb begin
    valid_o = !w_fifo_empty || w_bypass;
    pc_o    = r_last_pc;
    inst_o  = IF_NOP_INST;
    if (!w_fifo_empty) begin
      pc_o   = w_head.pc;
      inst_o = w_head.inst;
    end else if (w_bypass) begin
      pc_o   = r_resp_pc;
      inst_o = imem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_last_pc     <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_active <= 1'b1;

      case ({w_grant, imem_rvalid_i})
        2'b10:   r_outstanding <= r_outstanding + CntW'(1);
        2'b01:   r_outstanding <= r_outstanding - CntW'(1);
        default: ;
      endcase

      if (flush_i) begin
        r_fetch_pc <= word_align(flush_pc_i);
        r_resp_pc  <= word_align(flush_pc_i);
        // Everything still in flight is stale; a response landing now is
        // discarded directly and so is not counted.
        r_drop_cnt <= r_outstanding - CntW'(imem_rvalid_i);
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (imem_rvalid_i) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CntW'(1);
          else                  r_resp_pc  <= r_resp_pc + 32'd4;
        end
      end

      if (w_pop)                     r_last_pc <= w_head.pc;
      else if (w_bypass && !stall_i) r_last_pc <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch. A behavioural instruction
// memory answers grants in order after a configurable latency; every granted
// request pushes its expected {pc, inst} onto a scoreboard, which a flush
// clears and each delivered instruction pops and compares.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] TbResetPc = 32'hFFFF_FFF8;
  localparam int unsigned Depth     = 4;
`ifdef IF_BYPASS_EN
  localparam int ExpLat = 1;
`else
  localparam int ExpLat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC   (TbResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  rsp_t        pend[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          gnt_rand = 1'b0;
  int          n_pops   = 0;
  int          first_gnt_cyc;
  int          first_vld_cyc;
  logic [31:0] first_vld_pc;
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Starts and ends at a falling edge; inputs stall_i/flush_i are set by the caller.
  task automatic cycle();
    int lat;
    int due;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend[0].addr);
      end
    end
    imem_gnt_i = gnt_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
    #1;
    if (imem_req_o && imem_gnt_i) begin
      check("req_addr", imem_addr_o, m_pc);
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_addr_o, due: due});
      sb.push_back('{pc: m_pc, inst: mem_word(m_pc)});
      m_pc += 32'd4;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    if (imem_rvalid_i) void'(pend.pop_front());
    if (valid_o) begin
      if (first_vld_cyc < 0) begin
        first_vld_cyc = cyc;
        first_vld_pc  = pc_o;
      end
      if (!flush_i) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, valid_o}, 32'd0);
        end else begin
          check("out_pc", pc_o, sb[0].pc);
          check("out_inst", inst_o, sb[0].inst);
          if (!stall_i) begin
            void'(sb.pop_front());
            n_pops++;
          end
        end
      end
    end else begin
      check("nop_inst", inst_o, IF_NOP_INST);
    end
    check("credit", 32'(pend.size() <= Depth), 32'd1);
    if (flush_i) begin
      sb.delete();
      m_pc          = {flush_pc_i[31:2], 2'b00};
      first_vld_cyc = -1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    flush_pc_i    = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    pend.delete();
    sb.delete();
    m_pc          = TbResetPc;
    last_due      = 0;
    first_gnt_cyc = -1;
    first_vld_cyc = -1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, TbResetPc);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_first_valid(input logic [31:0] exp_pc, input string tag);
    int n = 0;
    while (first_vld_cyc < 0 && n < 60) begin
      cycle();
      n++;
    end
    check({tag, "_seen"}, 32'(first_vld_cyc >= 0), 32'd1);
    if (first_vld_cyc >= 0) check({tag, "_pc"}, first_vld_pc, exp_pc);
  endtask

  initial begin
    int n;

    // Startup from a PC that wraps; 1-cycle memory, grant always.
    do_reset();
    gnt_rand = 1'b0;
    lat_min  = 1;
    lat_max  = 1;
    repeat (20) cycle();
    check("first_pc_wrap", first_vld_pc, TbResetPc);
    check("first_latency", 32'(first_vld_cyc - first_gnt_cyc), 32'(ExpLat));
    check("throughput", 32'(n_pops >= 15), 32'd1);

    // Long stall: FIFO fills, requests stop, head holds.
    stall_i = 1'b1;
    repeat (10) cycle();
    check("stall_req_low", {31'b0, imem_req_o}, 32'd0);
    check("stall_valid", {31'b0, valid_o}, 32'd1);
    stall_i = 1'b0;
    repeat (20) cycle();

    // Flush to a misaligned target with three requests in flight.
    do_reset();
    lat_min = 8;
    lat_max = 8;
    n = 0;
    while (pend.size() < 3 && n < 20) begin
      cycle();
      n++;
    end
    check("three_outstanding", 32'(pend.size()), 32'd3);
    flush_i    = 1'b1;
    flush_pc_i = 32'h0000_0103;
    cycle();
    flush_i = 1'b0;
    lat_min = 1;
    lat_max = 1;
    wait_first_valid(32'h0000_0100, "flush1");
    repeat (20) cycle();

    // Flush coinciding with a response, then a second flush right after.
    lat_min = 2;
    lat_max = 2;
    repeat (10) cycle();
    n = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin
      cycle();
      n++;
    end
    flush_i    = 1'b1;
    flush_pc_i = 32'h0000_0200;
    cycle();
    flush_pc_i = 32'h0000_0300;
    cycle();
    flush_i = 1'b0;
    wait_first_valid(32'h0000_0300, "flush2");
    repeat (20) cycle();

    // Random grant, latency and stall over 1000 delivered instructions.
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 5;
    n_pops   = 0;
    n        = 0;
    while (n_pops < 1000 && n < 20000) begin
      stall_i = ($urandom_range(3, 0) == 0);
      cycle();
      n++;
    end
    stall_i = 1'b0;
    check("random_done", 32'(n_pops >= 1000), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
